// File: rtl/astro_game_ctrl.sv
// Turn sequencer for a two-player shooting game: launches shots on fire edges,
// scores hits against the current player and hands the turn over when it is spent.
//
// state   | meaning
// QI      | idle, scores cleared, waiting for start on a tick
// QGAME_1 | player 1 turn
// QGAME_2 | player 2 turn
// QDONE   | game over, scores held until start drops on a tick
module astro_game_ctrl #(
   parameter int WIN_SCORE = 10,
   parameter int SHOTS     = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       fire,
   input  logic       hit,
   input  logic       shot_done,
   output logic [1:0] state,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic       shot_launch,
   output logic       shot_active,
   output logic       target_reset,
   output logic [3:0] shots_left
);

   typedef enum logic [1:0] {
      QI      = 2'b00,
      QGAME_1 = 2'b01,
      QGAME_2 = 2'b10,
      QDONE   = 2'b11
   } state_t;

   localparam logic [3:0] WIN4   = 4'(WIN_SCORE);
   localparam logic [3:0] SHOTS4 = 4'(SHOTS);

   state_t     st;
   logic       fire_prev;
   logic       in_game;
   logic [3:0] cur_score;
   logic [3:0] score_inc;
   logic       turn_over;
   logic       launch_ok;

   assign state     = st;
   assign in_game   = (st == QGAME_1) || (st == QGAME_2);
   assign cur_score = (st == QGAME_2) ? p2_score : p1_score;
   assign score_inc = (cur_score == WIN4) ? cur_score : cur_score + 4'd1;

   // Turn end waits for the shot in flight to resolve; it also blocks any launch that cycle.
   assign turn_over = in_game && !shot_active && ((shots_left == 4'd0) || (cur_score == WIN4));
   assign launch_ok = tick && fire && !fire_prev && !shot_active && (shots_left != 4'd0)
                      && in_game && !turn_over;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st           <= QI;
         p1_score     <= 4'd0;
         p2_score     <= 4'd0;
         shots_left   <= SHOTS4;
         shot_active  <= 1'b0;
         shot_launch  <= 1'b0;
         target_reset <= 1'b0;
         fire_prev    <= 1'b0;
      end else begin
         shot_launch  <= 1'b0;
         target_reset <= 1'b0;
         if (tick) begin
            fire_prev <= fire;
         end
         case (st)
            QI: begin
               p1_score <= 4'd0;
               p2_score <= 4'd0;
               if (tick && start) begin
                  st           <= QGAME_1;
                  shots_left   <= SHOTS4;
                  target_reset <= 1'b1;
               end
            end
            QGAME_1, QGAME_2: begin
               if (turn_over) begin
                  if (st == QGAME_1) begin
                     st           <= QGAME_2;
                     shots_left   <= SHOTS4;
                     target_reset <= 1'b1;
                  end else begin
                     st <= QDONE;
                  end
               end else if (shot_active) begin
                  // A coincident shot_done is swallowed by the hit.
                  if (hit) begin
                     shot_active  <= 1'b0;
                     target_reset <= 1'b1;
                     if (st == QGAME_1) begin
                        p1_score <= score_inc;
                     end else begin
                        p2_score <= score_inc;
                     end
                  end else if (shot_done) begin
                     shot_active <= 1'b0;
                  end
               end else if (launch_ok) begin
                  shot_launch <= 1'b1;
                  shot_active <= 1'b1;
                  shots_left  <= shots_left - 4'd1;
               end
            end
            QDONE: begin
               if (tick && !start) begin
                  st       <= QI;
                  p1_score <= 4'd0;
                  p2_score <= 4'd0;
               end
            end
            default: st <= QI;
         endcase
      end
   end

endmodule
